// File: rtl/key_expand_seq_pkg.sv
// Shared types and constants for the sequential AES key-schedule engine.
// Holds the per-mode sizes, Rcon constants, the S-box table and GF(2^8) helpers.
package key_expand_seq_pkg;

  typedef enum logic [1:0] {
    KL_128 = 2'd0,
    KL_192 = 2'd1,
    KL_256 = 2'd2,
    KL_BAD = 2'd3
  } key_len_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  localparam int NK_128 = 4;
  localparam int NK_192 = 6;
  localparam int NK_256 = 8;
  localparam int NR_128 = 10;
  localparam int NR_192 = 12;
  localparam int NR_256 = 14;
  localparam int TOTAL_128 = 4 * (NR_128 + 1);
  localparam int TOTAL_192 = 4 * (NR_192 + 1);
  localparam int TOTAL_256 = 4 * (NR_256 + 1);

  localparam logic [7:0] RCON_INIT  = 8'h01;
  localparam logic [7:0] XTIME_POLY = 8'h1b;

  // Forward AES S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic int nk_of(input key_len_e kl);
    case (kl)
      KL_128:  return NK_128;
      KL_192:  return NK_192;
      KL_256:  return NK_256;
      default: return 0;
    endcase
  endfunction

  function automatic int total_of(input key_len_e kl);
    case (kl)
      KL_128:  return TOTAL_128;
      KL_192:  return TOTAL_192;
      KL_256:  return TOTAL_256;
      default: return 0;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? XTIME_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    logic [10:0] pos;
    pos = 11'(2047 - 8 * int'(b));
    return SBOX_TABLE[pos -: 8];
  endfunction

endpackage

// File: rtl/key_expand_seq_key_word_next.sv
// Single-step key-schedule word calculation: w[i] from w[i-1], w[i-Nk] and Rcon.
// Built from a byte rotator and four S-box lookups.
module rot_word (
  input  logic [31:0] in_word,
  output logic [31:0] out_word
);
  assign out_word = {in_word[23:0], in_word[31:24]};
endmodule

module sbox
  import key_expand_seq_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);
  assign out_byte = sub_byte(in_byte);
endmodule

module key_word_next (
  input  logic [31:0] prev_word,
  input  logic [31:0] old_word,
  input  logic [7:0]  rcon,
  input  logic        sel_rot,
  input  logic        sel_sub,
  output logic [31:0] next_word
);
  logic [31:0] rot;
  logic [31:0] sub_in;
  logic [31:0] sub_out;
  logic [31:0] t;

  rot_word u_rot (.in_word(prev_word), .out_word(rot));

  assign sub_in = sel_rot ? rot : prev_word;

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    sbox u_sbox (.in_byte(sub_in[8*b +: 8]), .out_byte(sub_out[8*b +: 8]));
  end

  // Rcon only enters on the rotate step; the AES-256 mid-key step is SubWord alone.
  always_comb begin
    t = prev_word;
    if (sel_rot)
      t = sub_out ^ {rcon, 24'h0};
    else if (sel_sub)
      t = sub_out;
  end

  assign next_word = old_word ^ t;
endmodule

// File: rtl/key_expand_seq.sv
// Self-sequencing AES key expansion: streams w[0..4*(Nr+1)-1] one word per
// handshake, keeping only a sliding window of the last Nk words.
module key_expand_seq
  import key_expand_seq_pkg::*;
#(
  parameter int NK_MAX = 8,
  parameter int IDX_W  = 6
) (
  input  logic                  pi_clk,
  input  logic                  pi_rst,
  input  logic                  pi_start,
  input  logic [1:0]            pi_key_len,
  input  logic [32*NK_MAX-1:0]  pi_key,
  output logic                  po_busy,
  output logic                  po_valid,
  input  logic                  pi_ready,
  output logic [31:0]           po_word,
  output logic [IDX_W-1:0]      po_idx,
  output logic                  po_last,
  output logic                  po_done,
  output logic                  po_err
);
  localparam int WIN_W = $clog2(NK_MAX);

  state_e           state;
  logic [31:0]      win [NK_MAX];
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] nk;
  logic [IDX_W-1:0] total_m1;
  logic [3:0]       mod_cnt;
  logic [3:0]       nk_m1;
  logic [7:0]       rcon;
  logic             valid;
  logic             busy;
  logic             done;
  logic             err;

  key_len_e         start_len;
  int               start_nk;
  logic             start_ok;
  logic             in_key;
  logic             sel_rot;
  logic             sel_sub;
  logic             handshake;
  logic [31:0]      derived_word;
  logic [31:0]      cur_word;

  always_comb begin
    start_len = key_len_e'(pi_key_len);
    start_nk  = nk_of(start_len);
    start_ok  = (start_nk != 0) && (start_nk <= NK_MAX);
  end

  // Until i reaches Nk the window still holds the raw key in order, so w[i] = win[i].
  assign in_key    = idx < nk;
  assign sel_rot   = !in_key && (mod_cnt == 4'd0);
  assign sel_sub   = !in_key && (nk == IDX_W'(8)) && (mod_cnt == 4'd4);
  assign handshake = valid && pi_ready;

  key_word_next u_next (
    .prev_word (win[nk_m1[WIN_W-1:0]]),
    .old_word  (win[0]),
    .rcon      (rcon),
    .sel_rot   (sel_rot),
    .sel_sub   (sel_sub),
    .next_word (derived_word)
  );

  assign cur_word = in_key ? win[idx[WIN_W-1:0]] : derived_word;

  always_ff @(posedge pi_clk) begin
    if (pi_rst) begin
      state    <= ST_IDLE;
      idx      <= '0;
      nk       <= '0;
      total_m1 <= '0;
      mod_cnt  <= '0;
      nk_m1    <= '0;
      rcon     <= '0;
      valid    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      for (int k = 0; k < NK_MAX; k++) win[k] <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pi_start) begin
            if (start_ok) begin
              for (int k = 0; k < NK_MAX; k++)
                win[k] <= pi_key[32*NK_MAX-1-32*k -: 32];
              nk       <= IDX_W'(start_nk);
              nk_m1    <= 4'(start_nk - 1);
              total_m1 <= IDX_W'(total_of(start_len) - 1);
              idx      <= '0;
              mod_cnt  <= '0;
              rcon     <= RCON_INIT;
              valid    <= 1'b1;
              busy     <= 1'b1;
              state    <= ST_RUN;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (handshake) begin
            // Past the raw key the window slides: oldest word out, new word in at Nk-1.
            if (!in_key) begin
              for (int k = 0; k < NK_MAX - 1; k++) win[k] <= win[k+1];
              win[nk_m1[WIN_W-1:0]] <= cur_word;
            end
            if (sel_rot) rcon <= xtime(rcon);
            mod_cnt <= (mod_cnt == nk_m1) ? 4'd0 : mod_cnt + 4'd1;
            if (idx == total_m1) begin
              idx   <= '0;
              valid <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign po_busy  = busy;
  assign po_valid = valid;
  assign po_word  = valid ? cur_word : '0;
  assign po_idx   = idx;
  assign po_last  = valid && (idx == total_m1);
  assign po_done  = done;
  assign po_err   = err;

endmodule

// File: tb/tb_key_expand_seq.sv
// Directed bench for key_expand_seq using the FIPS-197 key-expansion vectors
// for all three key lengths, plus backpressure, illegal-mode and reset cases.
module tb_key_expand_seq;
  localparam int NK_MAX = 8;
  localparam int IDX_W  = 6;

  localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  logic                 pi_clk = 1'b0;
  logic                 pi_rst;
  logic                 pi_start;
  logic [1:0]           pi_key_len;
  logic [32*NK_MAX-1:0] pi_key;
  logic                 pi_ready;
  logic                 po_busy;
  logic                 po_valid;
  logic [31:0]          po_word;
  logic [IDX_W-1:0]     po_idx;
  logic                 po_last;
  logic                 po_done;
  logic                 po_err;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] got [60];
  logic [31:0] ref128 [60];
  int          cyc;
  int          guard;

  key_expand_seq #(.NK_MAX(NK_MAX), .IDX_W(IDX_W)) dut (
    .pi_clk     (pi_clk),
    .pi_rst     (pi_rst),
    .pi_start   (pi_start),
    .pi_key_len (pi_key_len),
    .pi_key     (pi_key),
    .po_busy    (po_busy),
    .po_valid   (po_valid),
    .pi_ready   (pi_ready),
    .po_word    (po_word),
    .po_idx     (po_idx),
    .po_last    (po_last),
    .po_done    (po_done),
    .po_err     (po_err)
  );

  always #5 pi_clk = ~pi_clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Issue a one-cycle start and check that w[0] appears right after the accepting edge.
  task automatic applyStimulus(input logic [1:0] len, input logic [255:0] key);
    pi_key_len = len;
    pi_key     = key;
    pi_start   = 1'b1;
    @(posedge pi_clk); #1;
    pi_start   = 1'b0;
    pi_key     = '0;
    if (len != 2'd3) begin
      checkOutput("start_valid", 32'(po_valid), 32'd1);
      checkOutput("start_busy", 32'(po_busy), 32'd1);
      checkOutput("start_idx", 32'(po_idx), 32'd0);
      checkOutput("start_w0", po_word, key[255:224]);
    end
  endtask

  task automatic captureRun(input int n_words, input bit rand_ready, input int glitch_idx, output int cycles);
    int next_idx;
    bit stalled;
    logic [31:0] held_word;
    logic [IDX_W-1:0] held_idx;
    next_idx = 0;
    stalled  = 1'b0;
    held_word = '0;
    held_idx  = '0;
    cycles   = 0;
    while (next_idx < n_words && cycles < 1000) begin
      if (stalled) begin
        checkOutput("hold_word", po_word, held_word);
        checkOutput("hold_idx", 32'(po_idx), 32'(held_idx));
      end
      pi_start = (next_idx == glitch_idx);
      if (pi_start) begin
        pi_key_len = 2'd2;
        pi_key     = {8{32'hdeadbeef}};
      end
      pi_ready = rand_ready ? ($urandom_range(0, 99) < 40) : 1'b1;
      stalled  = 1'b0;
      if (po_valid && pi_ready) begin
        checkOutput("idx_seq", 32'(po_idx), 32'(next_idx));
        checkOutput("last_flag", 32'(po_last), 32'(next_idx == n_words - 1));
        got[next_idx] = po_word;
        next_idx++;
      end else if (po_valid) begin
        stalled   = 1'b1;
        held_word = po_word;
        held_idx  = po_idx;
      end else begin
        checkOutput("valid_in_run", 32'(po_valid), 32'd1);
      end
      @(posedge pi_clk); #1;
      cycles++;
    end
    pi_ready = 1'b0;
    pi_start = 1'b0;
    checkOutput("run_complete", 32'(next_idx), 32'(n_words));
  endtask

  // Called the cycle after the last handshake; leaves the DUT back in IDLE.
  task automatic finishRun();
    checkOutput("done_pulse", 32'(po_done), 32'd1);
    checkOutput("done_valid", 32'(po_valid), 32'd0);
    checkOutput("done_busy", 32'(po_busy), 32'd0);
    @(posedge pi_clk); #1;
    checkOutput("done_drop", 32'(po_done), 32'd0);
  endtask

  initial begin
    pi_rst     = 1'b1;
    pi_start   = 1'b0;
    pi_key_len = 2'd0;
    pi_key     = '0;
    pi_ready   = 1'b0;
    repeat (2) @(posedge pi_clk);
    #1;
    checkOutput("rst_valid", 32'(po_valid), 32'd0);
    checkOutput("rst_busy", 32'(po_busy), 32'd0);
    checkOutput("rst_word", po_word, 32'd0);
    checkOutput("rst_done", 32'(po_done), 32'd0);
    checkOutput("rst_err", 32'(po_err), 32'd0);
    pi_rst = 1'b0;
    @(posedge pi_clk); #1;

    $display("[TB] AES-128, ready held high");
    applyStimulus(2'd0, KEY128);
    captureRun(44, 1'b0, -1, cyc);
    checkOutput("a128_cycles", 32'(cyc), 32'd44);
    checkOutput("a128_w3", got[3], 32'h09cf4f3c);
    checkOutput("a128_w4", got[4], 32'ha0fafe17);
    checkOutput("a128_w5", got[5], 32'h88542cb1);
    checkOutput("a128_w8", got[8], 32'hf2c295f2);
    checkOutput("a128_w40", got[40], 32'hd014f9a8);
    checkOutput("a128_w43", got[43], 32'hb6630ca6);
    for (int k = 0; k < 44; k++) ref128[k] = got[k];
    // A start presented while in DONE must be dropped, not queued.
    pi_start   = 1'b1;
    pi_key_len = 2'd2;
    pi_key     = KEY256;
    checkOutput("done_pulse", 32'(po_done), 32'd1);
    @(posedge pi_clk); #1;
    pi_start = 1'b0;
    checkOutput("done_drop", 32'(po_done), 32'd0);
    checkOutput("done_start_busy", 32'(po_busy), 32'd0);
    @(posedge pi_clk); #1;
    checkOutput("done_start_busy2", 32'(po_busy), 32'd0);
    checkOutput("done_start_valid", 32'(po_valid), 32'd0);

    $display("[TB] AES-192, ready held high");
    applyStimulus(2'd1, KEY192);
    captureRun(52, 1'b0, -1, cyc);
    checkOutput("a192_cycles", 32'(cyc), 32'd52);
    checkOutput("a192_w6", got[6], 32'hfe0c91f7);
    checkOutput("a192_w7", got[7], 32'h2402f5a5);
    checkOutput("a192_w51", got[51], 32'h01002202);
    finishRun();

    $display("[TB] AES-256, ready held high");
    applyStimulus(2'd2, KEY256);
    captureRun(60, 1'b0, -1, cyc);
    checkOutput("a256_cycles", 32'(cyc), 32'd60);
    checkOutput("a256_w8", got[8], 32'h9ba35411);
    checkOutput("a256_w9", got[9], 32'h8e6925af);
    checkOutput("a256_w12", got[12], 32'ha8b09c1a);
    checkOutput("a256_w13", got[13], 32'h93d194cd);
    checkOutput("a256_w59", got[59], 32'h706c631e);
    finishRun();

    $display("[TB] AES-128, random ready and a stray start mid-run");
    applyStimulus(2'd0, KEY128);
    captureRun(44, 1'b1, 10, cyc);
    for (int k = 0; k < 44; k++) checkOutput("a128_bp_seq", got[k], ref128[k]);
    checkOutput("a128_bp_w43", got[43], 32'hb6630ca6);
    finishRun();

    $display("[TB] illegal key length");
    applyStimulus(2'd3, KEY128);
    checkOutput("bad_err", 32'(po_err), 32'd1);
    checkOutput("bad_busy", 32'(po_busy), 32'd0);
    checkOutput("bad_valid", 32'(po_valid), 32'd0);
    @(posedge pi_clk); #1;
    checkOutput("bad_err_drop", 32'(po_err), 32'd0);
    checkOutput("bad_busy2", 32'(po_busy), 32'd0);

    $display("[TB] reset in the middle of an AES-256 run");
    applyStimulus(2'd2, KEY256);
    pi_ready = 1'b1;
    guard = 0;
    while (po_idx != 6'd20 && guard < 100) begin
      @(posedge pi_clk); #1;
      guard++;
    end
    checkOutput("mid_idx", 32'(po_idx), 32'd20);
    pi_rst = 1'b1;
    @(posedge pi_clk); #1;
    pi_rst   = 1'b0;
    pi_ready = 1'b0;
    checkOutput("mid_rst_valid", 32'(po_valid), 32'd0);
    checkOutput("mid_rst_busy", 32'(po_busy), 32'd0);
    checkOutput("mid_rst_word", po_word, 32'd0);
    checkOutput("mid_rst_idx", 32'(po_idx), 32'd0);
    checkOutput("mid_rst_last", 32'(po_last), 32'd0);
    checkOutput("mid_rst_done", 32'(po_done), 32'd0);
    applyStimulus(2'd0, KEY128);
    captureRun(44, 1'b0, -1, cyc);
    checkOutput("post_rst_cycles", 32'(cyc), 32'd44);
    checkOutput("post_rst_w4", got[4], 32'ha0fafe17);
    checkOutput("post_rst_w43", got[43], 32'hb6630ca6);
    finishRun();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/key_expand_seq.md
Name: key_expand_seq

Overview:
Sequential AES key-schedule engine for AES-128, AES-192 and AES-256 (Nk = 4/6/8), selected per run.
- Emits the full expanded key w[0..4*(Nr+1)-1] as a stream of one 32-bit word per cycle, under valid/ready flow control.
- Generalises the single-step next-word calculation into a self-sequencing block. It holds a sliding window of the last Nk words, tracks Rcon, and adds the AES-256 extra SubWord step.
- Feeds round-key storage or an on-the-fly cipher datapath.

Parameters:
NK_MAX, 8, largest key length supported in words (legal: 4, 6, 8); sizes the window and key register; modes with Nk > NK_MAX are rejected
IDX_W, 6, width of the word index (must hold 59)

Ports:
pi_clk  input  1  clock
pi_rst  input  1  synchronous reset, active-high
pi_start  input  1  start request; accepted only when po_busy=0
pi_key_len  input  2  0=AES-128, 1=AES-192, 2=AES-256, 3=illegal; sampled with accepted pi_start
pi_key  input  32*NK_MAX  cipher key, left-aligned; w[j]=pi_key[32*NK_MAX-1-32j -: 32]; unused low words ignored
po_busy  output  1  high from accepted start until the last word is accepted
po_valid  output  1  po_word/po_idx/po_last valid
pi_ready  input  1  consumer accepts the current word when po_valid&&pi_ready
po_word  output  32  expanded key word w[po_idx]; byte 0 in bits [31:24]
po_idx  output  IDX_W  index i of po_word
po_last  output  1  high with the final word (i = 43/51/59)
po_done  output  1  one-cycle pulse the cycle after the last word is accepted
po_err  output  1  one-cycle pulse when a start with an illegal/unsupported pi_key_len is rejected

Behaviour:
- Reset values:
  - The synchronous reset (pi_rst high at a clock edge) returns the state to IDLE.
  - All outputs become 0; the window, counters and Rcon are cleared. pi_rst overrides everything, including mid-run.
- States are IDLE, RUN and DONE.
  - IDLE: if pi_start and the mode is legal, latch the key into the window, Nk, total = 4*(Nk+7), i=0, and rcon=8'h01. Then go to RUN.
  - IDLE with an illegal mode: pulse po_err and stay in IDLE.
- Latency: po_valid rises the cycle after the accepting edge, presenting w[0].
- RUN handshake:
  - po_valid stays high. po_word, po_idx and po_last hold stable until the handshake.
  - On a handshake, i increments and the next word appears the following cycle. With pi_ready held high, throughput is 1 word/cycle and there are no bubbles.
- Word generation:
  - i < Nk: w[i] is taken directly from the key.
  - i >= Nk: t=w[i-1].
    - If i mod Nk == 0: t = SubWord(RotWord(t)) ^ {rcon,24'h0}; rcon advances to xtime(rcon) on the handshake of that word.
    - Else if Nk==8 and i mod Nk == 4: t = SubWord(t).
    - Then w[i] = w[i-Nk] ^ t.
  - RotWord is a left byte rotate (bytes b0b1b2b3 -> b1b2b3b0, b0 in [31:24]). xtime is a GF(2^8) doubling with 0x1b reduction. rcon never exceeds 0x36 for legal modes.
- Window: an Nk-deep shift register of the most recent words. It shifts in the newly accepted word on each handshake. A mod-Nk counter replaces any divider.
- po_last = (i == total-1). The handshake on the last word goes to DONE and drops po_valid and po_busy in the same cycle.
- DONE: pulse po_done for one cycle, then return to IDLE. A pi_start during DONE is ignored, not queued.
- pi_start while busy is ignored, with no error. pi_key and pi_key_len are don't-care outside the accepting cycle.
- pi_ready with po_valid=0 has no effect. Backpressure may last indefinitely.

Decomposition:
- Shared package holds:
  - key-length enum (KL_128/KL_192/KL_256) and FSM state enum.
  - NK, NR and total-word constants per mode; RCON_INIT=8'h01 and XTIME_POLY=8'h1b.
- One natural sub-module, key_word_next (combinational): (prev word, w[i-Nk], rcon, sel_rot, sel_sub) -> w[i].
  - Built from the existing rot_word and four sbox instances.
  - key_expand_seq holds the FSM, counters, window and handshake.

Test Plan:
- AES-128 key 2b7e151628aed2a6abf7158809cf4f3c, ready=1 -> w4=a0fafe17, w43=b6630ca6 with po_last; 44 words in 44 consecutive cycles; po_done next cycle.
- AES-192 key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> w6=fe0c91f7, w51=01002202, po_last at idx 51.
- AES-256 key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> w8=9ba35411, w12=a8b09c1a (SubWord-only path), w59=706c631e.
- AES-128 with pseudo-random pi_ready (~40%) -> identical word sequence to the ready=1 run; words held stable while ready=0; no skipped or duplicated idx.
- pi_key_len=3 start -> po_err pulse, po_busy stays 0. Second pi_start mid-run -> ignored, sequence unchanged.
- pi_rst asserted at idx 20 of an AES-256 run -> next cycle po_valid=0, po_busy=0, all outputs 0; a following AES-128 start then produces the correct vector from w0.
